// File: rtl/frac_lut6_bl_wl_writer.sv
// Serial bitstream writer for the frac_lut6 RS-latch configuration memory.
// Each accepted bit drives one bitline, then the matching wordline is pulsed
// with fixed setup/pulse/hold windows timed by a single down-counter.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; all lines low
//   S_LOAD  | din_ready high; waiting for the next configuration bit
//   S_SETUP | bl driven, wl low; bitline settles before the wordline rises
//   S_PULSE | wl[bit_idx] high; latch captures bl
//   S_HOLD  | wl low, bl still driven; bl clears on exit
//   S_DONE  | one-cycle done pulse, then back to idle
module frac_lut6_bl_wl_writer #(
  parameter int NUM_BITS        = 64,
  parameter int SETUP_CYCLES    = 1,
  parameter int WL_PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES     = 1
) (
  input  logic                        prog_clk,
  input  logic                        pReset,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        din,
  input  logic                        din_valid,
  output logic                        din_ready,
  output logic [0:NUM_BITS-1]         bl,
  output logic [0:NUM_BITS-1]         wl,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(NUM_BITS)-1:0] bit_idx
);

  localparam int IDX_W   = $clog2(NUM_BITS);
  localparam int MAX_SP  = (SETUP_CYCLES > WL_PULSE_CYCLES) ? SETUP_CYCLES : WL_PULSE_CYCLES;
  localparam int MAX_CYC = (MAX_SP > HOLD_CYCLES) ? MAX_SP : HOLD_CYCLES;
  // Counter holds (window length - 1), so it only needs to reach MAX_CYC-1.
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(WL_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SETUP = 3'd2,
    S_PULSE = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [0:NUM_BITS-1] bl_q, bl_d;
  logic [0:NUM_BITS-1] wl_q, wl_d;
  logic                done_q, done_d;

  // Next-state, window timing and registered-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    bl_d      = bl_q;
    wl_d      = '0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          bit_idx_d = '0;
        end
      end

      S_LOAD: begin
        // din_ready is high for the whole of LOAD, so valid alone completes the handshake.
        if (din_valid) begin
          bl_d            = '0;
          bl_d[bit_idx_q] = din;
          cnt_d           = SETUP_LOAD;
          state_d         = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt_q == '0) begin
          wl_d[bit_idx_q] = 1'b1;
          cnt_d           = PULSE_LOAD;
          state_d         = S_PULSE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = HOLD_LOAD;
          state_d = S_HOLD;
        end else begin
          wl_d[bit_idx_q] = 1'b1;
          cnt_d           = cnt_q - CNT_W'(1);
        end
      end

      S_HOLD: begin
        if (cnt_q == '0) begin
          bl_d = '0;
          if (bit_idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            state_d   = S_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_DONE: begin
        bit_idx_d = '0;
        state_d   = S_IDLE;
      end

      default: begin
        bl_d      = '0;
        bit_idx_d = '0;
        state_d   = S_IDLE;
      end
    endcase

    // Abort overrides everything, including a start seen in IDLE.
    if (abort) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      bit_idx_d = '0;
      bl_d      = '0;
      wl_d      = '0;
      done_d    = 1'b0;
    end
  end

  // State and output registers; reset clears wl without waiting for a clock.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      bl_q      <= '0;
      wl_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      bl_q      <= bl_d;
      wl_q      <= wl_d;
      done_q    <= done_d;
    end
  end

  assign din_ready = (state_q == S_LOAD);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign bl        = bl_q;
  assign wl        = wl_q;
  assign bit_idx   = bit_idx_q;

endmodule

// File: tb/tb_frac_lut6_bl_wl_writer.sv
// Self-checking bench for frac_lut6_bl_wl_writer: table of full passes with a
// scoreboard-driven wordline monitor, plus hand sequences for abort, async
// reset and a non-default parameter set.
module tb_frac_lut6_bl_wl_writer;

  localparam int N  = 64;
  localparam int SU = 1;
  localparam int PW = 2;
  localparam int HD = 1;

  logic          prog_clk = 1'b0;
  logic          pReset = 1'b0;
  logic          start = 1'b0, abort = 1'b0, din = 1'b0, din_valid = 1'b0;
  logic          din_ready, busy, done;
  logic [0:N-1]  bl, wl;
  logic [5:0]    bit_idx;

  logic          start_s = 1'b0, abort_s = 1'b0, din_s = 1'b0, dv_s = 1'b0;
  logic          rdy_s, busy_s, done_s;
  logic [0:7]    bl_s, wl_s;
  logic [2:0]    idx_s;

  frac_lut6_bl_wl_writer u_dut (
    .prog_clk (prog_clk), .pReset (pReset), .start (start), .abort (abort),
    .din (din), .din_valid (din_valid), .din_ready (din_ready),
    .bl (bl), .wl (wl), .busy (busy), .done (done), .bit_idx (bit_idx)
  );

  frac_lut6_bl_wl_writer #(
    .NUM_BITS (8), .SETUP_CYCLES (3), .WL_PULSE_CYCLES (4), .HOLD_CYCLES (2)
  ) u_sweep (
    .prog_clk (prog_clk), .pReset (pReset), .start (start_s), .abort (abort_s),
    .din (din_s), .din_valid (dv_s), .din_ready (rdy_s),
    .bl (bl_s), .wl (wl_s), .busy (busy_s), .done (done_s), .bit_idx (idx_s)
  );

  always #5 prog_clk = ~prog_clk;

  int tcyc = 0;
  always @(posedge prog_clk) tcyc <= tcyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  typedef struct {
    int   idx;
    logic d;
    int   t;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [63:0] data;
    int          max_gap;
    bit          poke;
    logic [63:0] exp_mem;
  } vec_t;
  vec_t vecs[5];

  // Wordline monitor: checks every pulse against the scoreboard and builds a latch image.
  bit           mon_en = 1'b0;
  logic [0:N-1] prev_wl, rise_bl, oh;
  logic [63:0]  mem;
  int           rise_t, fall_t, pulses, fi;
  bit           in_hold;
  sb_t          e;

  always @(negedge prog_clk) begin
    if (!mon_en || pReset) begin
      prev_wl = '0;
      in_hold = 1'b0;
      pulses  = 0;
      mem     = '0;
    end else begin
      chk("wl_onehot0", 64'($onehot0(wl)), 64'd1);
      if (din_ready) chk("load_lines_clear", bl | wl, 64'd0);
      if (wl != '0 && prev_wl == '0) begin
        fi = 0;
        for (int k = 0; k < N; k++) if (wl[k]) fi = k;
        oh = '0;
        oh[fi] = 1'b1;
        pulses++;
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("wl_index", fi, e.idx);
          chk("bl_data", bl[fi], e.d);
          chk("bl_other_bits", bl & ~oh, 64'd0);
          chk("setup_len", tcyc - e.t, SU + 1);
        end
        mem[fi] = bl[fi];
        rise_t  = tcyc;
        rise_bl = bl;
      end else if (wl != '0) begin
        chk("wl_stable", wl, prev_wl);
        chk("bl_stable_pulse", bl, rise_bl);
      end else if (prev_wl != '0) begin
        chk("pulse_len", tcyc - rise_t, PW);
        chk("bl_stable_fall", bl, rise_bl);
        fall_t  = tcyc;
        in_hold = 1'b1;
      end else if (in_hold) begin
        if (din_ready || done) begin
          chk("hold_len", tcyc - fall_t, HD);
          in_hold = 1'b0;
        end else begin
          chk("bl_stable_hold", bl, rise_bl);
        end
      end
      prev_wl = wl;
    end
  end

  // Drives one full pass; gaps are inserted only while the DUT sits in LOAD.
  task automatic run_pass(input logic [63:0] data, input int max_gap, input bit poke,
                          output int done_rel, output int gaps);
    int  i, gap, t0;
    sb_t s;
    i = 0;
    gaps = 0;
    done_rel = -1;
    gap = int'($urandom_range(max_gap, 0));
    @(negedge prog_clk);
    start = 1'b1;
    din_valid = 1'b1;
    din = data[0];
    t0 = tcyc;
    for (int c = 0; c < 2000; c++) begin
      @(negedge prog_clk);
      start = 1'b0;
      if (done) begin
        done_rel = tcyc - t0;
        break;
      end
      if (din_ready && i < N) begin
        if (gap > 0) begin
          din_valid = 1'b0;
          gap--;
          gaps++;
        end else begin
          din_valid = 1'b1;
          din = data[i];
          s.idx = i;
          s.d = data[i];
          s.t = tcyc;
          sb_q.push_back(s);
          if (poke && i == 3) start = 1'b1;
          i++;
          gap = int'($urandom_range(max_gap, 0));
        end
      end else if (i >= N) begin
        din_valid = 1'b0;
      end
    end
    din_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic pass_and_check(input vec_t v);
    int done_rel, gaps;
    mon_en = 1'b0;
    sb_q.delete();
    @(negedge prog_clk);
    @(negedge prog_clk);
    mon_en = 1'b1;
    run_pass(v.data, v.max_gap, v.poke, done_rel, gaps);
    chk("done_cycle", done_rel, 1 + N * (1 + SU + PW + HD) + gaps);
    @(negedge prog_clk);
    chk("idle_after_done", busy, 1'b0);
    chk("done_one_cycle", done, 1'b0);
    chk("pulse_count", pulses, N);
    chk("sb_drained", sb_q.size(), 0);
    chk("latch_image", mem, v.exp_mem);
  endtask

  logic [7:0] pat_s, mem_s;
  logic [0:7] prev_s;
  int         found, seen_done, rises, hi, last_rise, done_t, t0s;

  initial begin
    vecs[0] = '{64'h5555_5555_5555_5555, 0, 1'b0, 64'h5555_5555_5555_5555};
    vecs[1] = '{64'hAAAA_AAAA_AAAA_AAAA, 0, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA};
    vecs[2] = '{64'hDEAD_BEEF_0123_4567, 7, 1'b0, 64'hDEAD_BEEF_0123_4567};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[4] = '{64'h8000_0000_0000_0001, 7, 1'b1, 64'h8000_0000_0000_0001};

    // Reset state.
    #2 pReset = 1'b1;
    #2;
    chk("rst_bl", bl, 64'd0);
    chk("rst_wl", wl, 64'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_din_ready", din_ready, 1'b0);
    chk("rst_bit_idx", bit_idx, 6'd0);
    @(negedge prog_clk);
    @(negedge prog_clk);
    pReset = 1'b0;

    // Start leaves IDLE on the next edge.
    @(negedge prog_clk);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_din_ready", din_ready, 1'b1);
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    chk("abort_from_load_busy", busy, 1'b0);

    // Abort beats start in IDLE.
    start = 1'b1;
    abort = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_wins_busy", busy, 1'b0);
    chk("abort_wins_ready", din_ready, 1'b0);

    foreach (vecs[v]) pass_and_check(vecs[v]);

    // Abort during the pulse of bit 17.
    mon_en = 1'b0;
    din_valid = 1'b1;
    din = 1'b1;
    @(negedge prog_clk);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 400; c++) begin
      if (wl[17]) begin
        found = 1;
        break;
      end
      @(negedge prog_clk);
    end
    chk("abort_reach_bit17", found, 1);
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    din_valid = 1'b0;
    chk("abort_wl", wl, 64'd0);
    chk("abort_bl", bl, 64'd0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", din_ready, 1'b0);
    chk("abort_bit_idx", bit_idx, 6'd0);
    seen_done = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) seen_done = 1;
      @(negedge prog_clk);
    end
    chk("abort_no_done", seen_done, 0);
    pass_and_check(vecs[0]);

    // Asynchronous reset between edges during the pulse of bit 5.
    mon_en = 1'b0;
    din_valid = 1'b1;
    din = 1'b1;
    @(negedge prog_clk);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 200; c++) begin
      if (wl[5]) begin
        found = 1;
        break;
      end
      @(negedge prog_clk);
    end
    chk("rst_reach_bit5", found, 1);
    #2 pReset = 1'b1;
    #1;
    chk("async_rst_wl", wl, 64'd0);
    chk("async_rst_bl", bl, 64'd0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_bit_idx", bit_idx, 6'd0);
    @(negedge prog_clk);
    pReset = 1'b0;
    din_valid = 1'b0;
    @(negedge prog_clk);
    chk("post_rst_idle", busy, 1'b0);

    // Parameter sweep instance: 8 bits, 3/4/2 windows, 10 cycles per bit.
    pat_s = 8'b1011_0010;
    mem_s = '0;
    prev_s = '0;
    rises = 0;
    hi = 0;
    last_rise = 0;
    done_t = -1;
    @(negedge prog_clk);
    start_s = 1'b1;
    dv_s = 1'b1;
    din_s = pat_s[0];
    t0s = tcyc;
    for (int c = 0; c < 150; c++) begin
      @(negedge prog_clk);
      start_s = 1'b0;
      din_s = pat_s[idx_s];
      if (wl_s != '0 && prev_s == '0) begin
        fi = 0;
        for (int k = 0; k < 8; k++) if (wl_s[k]) fi = k;
        if (rises == 0) chk("sweep_first_rise", tcyc - t0s, 5);
        else chk("sweep_bit_period", tcyc - last_rise, 10);
        chk("sweep_wl_index", fi, rises);
        last_rise = tcyc;
        rises++;
        mem_s[fi] = bl_s[fi];
        hi = 1;
      end else if (wl_s != '0) begin
        hi++;
      end else if (prev_s != '0) begin
        chk("sweep_pulse_len", hi, 4);
      end
      prev_s = wl_s;
      if (done_s) begin
        done_t = tcyc - t0s;
        break;
      end
    end
    dv_s = 1'b0;
    chk("sweep_done_cycle", done_t, 81);
    chk("sweep_pulse_count", rises, 8);
    chk("sweep_latch_image", mem_s, pat_s);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frac_lut6_bl_wl_writer.md
# frac_lut6_bl_wl_writer

Programming-side driver for the frac_lut6 RS-latch configuration memory. It accepts a serial configuration bitstream over a valid/ready handshake and writes it one latch at a time. For each bit it drives the latch's `bl` line with the data and pulses its `wl` line with programmable setup, pulse and hold windows. It sits in the fabric programming path, between the bitstream loader and the `bl`/`wl` inputs of one frac_lut6 logical tile.

## Interface
- `NUM_BITS`, 64: number of latches; width of `bl` and `wl`.
- `SETUP_CYCLES`, 1: cycles `bl` is stable before `wl` rises; must be ≥1.
- `WL_PULSE_CYCLES`, 2: cycles `wl` is held high; must be ≥1.
- `HOLD_CYCLES`, 1: cycles `bl` is held after `wl` falls; must be ≥1.

Ports:
- `prog_clk`  in  1  programming clock; the only clock.
- `pReset`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a full programming pass.
- `abort`  in  1  synchronous abort; returns the block to IDLE.
- `din`  in  1  configuration bit; bit 0 is written to latch 0.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  the block accepts `din` this cycle.
- `bl`  out  `[0:NUM_BITS-1]`  bitline data, registered.
- `wl`  out  `[0:NUM_BITS-1]`  wordline enables, registered; at most one bit is high.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when all bits have been written.
- `bit_idx`  out  `$clog2(NUM_BITS)`  index of the latch currently being written.

## Operation
States: IDLE, LOAD, SETUP, PULSE, HOLD, DONE.
- IDLE: `start`=1 and `abort`=0 -> LOAD, with `bit_idx`←0. Otherwise the block stays in IDLE.
- LOAD: `din_ready`=1.
  - On `din_valid` & `din_ready`: `bl`←one-hot-masked vector (bit `bit_idx` = `din`, all other bits 0), then go to SETUP.
  - If `din_valid`=0, the block waits indefinitely.
- SETUP: `wl`=0 and `bl` is held. Lasts `SETUP_CYCLES`, then goes to PULSE.
- PULSE: `wl[bit_idx]`=1 and all other `wl` bits are 0. `bl` is held. Lasts `WL_PULSE_CYCLES`, then goes to HOLD.
- HOLD: `wl`=0 and `bl` is held. Lasts `HOLD_CYCLES`.
  - On exit, `bl`←0.
  - If `bit_idx`==`NUM_BITS-1`, go to DONE.
  - Otherwise `bit_idx`++ and go to LOAD.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. `bit_idx` returns to 0.
- `start` is ignored in every state other than IDLE.
- `abort`=1 in any state, on the next edge:
  - the block goes to IDLE;
  - `wl`←0 and `bl`←0;
  - `bit_idx`←0;
  - no `done` pulse is generated.
- If `abort` and `start` are both high in IDLE, `abort` wins and the block stays in IDLE.
- A single cycle counter times SETUP, PULSE and HOLD. It is sized for the maximum of the three parameters and reloads on each state entry.

## Timing
- Reset values, applied asynchronously on `pReset`:
  - state=IDLE;
  - `bl`=0, `wl`=0, `bit_idx`=0;
  - `busy`=0, `done`=0, `din_ready`=0.
- Reset asserted mid-PULSE drops `wl` immediately, without waiting for a clock edge.
- All outputs are registered. `din_ready` and `busy` are decoded from registered state only, with no combinational path from any input.
- Per-bit latency, with `din_valid` held high: `1 + SETUP_CYCLES + WL_PULSE_CYCLES + HOLD_CYCLES` cycles. With defaults this is 5 cycles.
- Full pass with defaults and `din_valid` held high: `start` at edge 0 gives LOAD at cycle 1, `done` at cycle 1+64·5 = 321, and IDLE at cycle 322.
- `bl` is stable from the first SETUP cycle through the last HOLD cycle. `wl` never rises in the same cycle that `bl` changes, and never falls in the same cycle that `bl` changes.
- Gaps where `din_valid`=0 only lengthen LOAD. The SETUP, PULSE and HOLD widths are unaffected.

## Test plan
- Reset behaviour: assert `pReset` -> all outputs are 0. Release it and pulse `start` -> `busy`=1 and `din_ready`=1 on the next cycle.
- Single full pass, defaults, alternating bitstream 1,0,1,0…, `din_valid` held high:
  - each `wl[i]` is high for exactly 2 cycles, in index order;
  - `bl[i]` equals the pattern bit while `wl[i]` is high;
  - `done` pulses at cycle 321;
  - a scoreboard latch model ends at 0x5555…/0xAAAA… matching the stream order.
- Backpressure: insert random 0–7 cycle `din_valid` gaps -> pulse widths stay 1/2/1, and the written data matches.
- Abort during PULSE of bit 17 -> on the next edge `wl`=0, `bl`=0, state is IDLE and `done` is never asserted. A new `start` restarts writing from bit 0.
- Asynchronous reset mid-PULSE of bit 5 (between clock edges) -> `wl` goes to 0 immediately. `start` asserted while `busy`=1 has no effect.
- Parameter sweep with `NUM_BITS`=8, `SETUP_CYCLES`=3, `WL_PULSE_CYCLES`=4, `HOLD_CYCLES`=2 -> 10 cycles per bit, and `done` at cycle 81.
